memory_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous RAM (write-through port, 1-cycle registered read) among `P_ports` requesters, e.g. CPU core, OAM/DMA engine and debug port. It muxes the winning requester's address, write-enable and data onto the RAM port each cycle and routes read data back with a per-port valid strobe. Optional bus locking lets a DMA-style requester hold the RAM for bounded bursts.

---
 rtl/memory_arbiter_pkg.sv | 29 ++
 rtl/rr_pick.sv | 55 +++++
 rtl/memory_arbiter.sv | 153 +++++++++++++++
 tb/tb_memory_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared types, constants and helpers for the memory arbiter slice.
//   arb_state_t       : arbiter FSM state (S_ARB = round robin, S_LOCK = held)
//   LP_LOCK_CNT_BITS  : width of the saturating locked-grant counter
//   fn_wrap_idx       : (base + off) modulo n, for base < n and off < n
// No ports (package).
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    typedef enum logic [0:0] {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } arb_state_t;

    localparam int LP_LOCK_CNT_BITS = 16;

    // Both operands are already below n, so one conditional subtract is
    // enough; this keeps the wrap correct for non power-of-two port counts.
    function automatic int fn_wrap_idx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans I_req starting at I_ptr, wrapping
// modulo P_ports, and returns the first requesting port.
// Ports:
//   I_req  [P_ports]     : request vector
//   I_ptr  [P_idx_bits]  : index of the highest-priority port (< P_ports)
//   O_gnt  [P_ports]     : one-hot grant, zero when nothing requests
//   O_idx  [P_idx_bits]  : binary index of the granted port (0 when none)
//   O_any                : at least one port is requesting
// -----------------------------------------------------------------------------
module rr_pick
    import memory_arbiter_pkg::*;
#(
    parameter int P_ports    = 2,
    parameter int P_idx_bits = (P_ports > 2) ? 2 : 1
)(
    input  logic [P_ports-1:0]    I_req,
    input  logic [P_idx_bits-1:0] I_ptr,
    output logic [P_ports-1:0]    O_gnt,
    output logic [P_idx_bits-1:0] O_idx,
    output logic                  O_any
);

    // Candidate gi is the port reached gi steps after the pointer.
    logic [P_idx_bits-1:0] w_cand_idx [P_ports];
    logic [P_ports-1:0]    w_hit;
    logic [P_idx_bits-1:0] w_idx;
    logic                  w_any;

    genvar gi;
    generate
        for (gi = 0; gi < P_ports; gi++) begin : g_scan
            assign w_cand_idx[gi] = P_idx_bits'(fn_wrap_idx(int'(I_ptr), gi, P_ports));
            assign w_hit[gi]      = I_req[w_cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end down so the nearest hit to the pointer wins.
    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        for (int k = P_ports - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_idx = w_cand_idx[k];
                w_any = 1'b1;
            end
        end
    end

    assign O_idx = w_idx;
    assign O_any = w_any;
    assign O_gnt = w_any ? ({{(P_ports-1){1'b0}}, 1'b1} << w_idx) : '0;

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Round-robin arbiter sharing one single-port synchronous RAM (1-cycle
// registered read) among P_ports requesters. The RAM itself lives in the
// parent; this block only muxes the winner onto the RAM port and returns a
// per-port read-valid strobe.
//
// Optional feature macro: MEMORY_ARBITER_LOCK_EN
//   When defined, adds parameter P_lock_max and port I_lock so a requester can
//   hold the RAM for up to P_lock_max consecutive grants.
//
// Ports:
//   I_clock, I_reset        : clock, synchronous active-high reset
//   I_req/I_wren [P]        : per-port request and write qualifier
//   I_addr [P*A], I_data [P*D] : flattened per-port address / write data
//   I_lock [P]              : hold grant after this access (macro only)
//   O_gnt [P]               : one-hot combinational grant
//   O_rvalid [P]            : read data valid, one cycle after a read grant
//   O_rdata [D]             : shared read data (passthrough of I_mem_data)
//   O_mem_addr/O_mem_wren/O_mem_data : RAM command port
//   I_mem_data [D]          : RAM registered read data
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int P_ports     = 2,
    parameter int P_data_bits = 8,
    parameter int P_addr_bits = 10
`ifdef MEMORY_ARBITER_LOCK_EN
    ,
    parameter int P_lock_max  = 256
`endif
)(
    input  logic                           I_clock,
    input  logic                           I_reset,
    input  logic [P_ports-1:0]             I_req,
    input  logic [P_ports-1:0]             I_wren,
    input  logic [P_ports*P_addr_bits-1:0] I_addr,
    input  logic [P_ports*P_data_bits-1:0] I_data,
`ifdef MEMORY_ARBITER_LOCK_EN
    input  logic [P_ports-1:0]             I_lock,
`endif
    output logic [P_ports-1:0]             O_gnt,
    output logic [P_ports-1:0]             O_rvalid,
    output logic [P_data_bits-1:0]         O_rdata,
    output logic [P_addr_bits-1:0]         O_mem_addr,
    output logic                           O_mem_wren,
    output logic [P_data_bits-1:0]         O_mem_data,
    input  logic [P_data_bits-1:0]         I_mem_data
);

    localparam int LP_IDX_BITS = (P_ports > 2) ? 2 : 1;

    logic [LP_IDX_BITS-1:0] r_ptr;
    logic [P_ports-1:0]     r_rvalid;

    logic [P_ports-1:0]     w_pick_gnt;
    logic [LP_IDX_BITS-1:0] w_pick_idx;
    logic                   w_pick_any;

    logic [P_ports-1:0]     w_gnt_vec;
    logic [LP_IDX_BITS-1:0] w_gnt_idx;
    logic                   w_any;
    logic [LP_IDX_BITS-1:0] w_sel;

    rr_pick #(
        .P_ports    (P_ports),
        .P_idx_bits (LP_IDX_BITS)
    ) u_rr_pick (
        .I_req (I_req),
        .I_ptr (r_ptr),
        .O_gnt (w_pick_gnt),
        .O_idx (w_pick_idx),
        .O_any (w_pick_any)
    );

`ifdef MEMORY_ARBITER_LOCK_EN
    arb_state_t                  r_state;
    logic [LP_IDX_BITS-1:0]      r_owner;
    logic [LP_LOCK_CNT_BITS-1:0] r_lock_cnt;

    logic                        w_locked;
    logic                        w_start_lock;
    logic                        w_release;
    logic [LP_LOCK_CNT_BITS-1:0] w_cnt_inc;

    // The owner only bypasses round robin while it keeps requesting; once it
    // drops its request that cycle falls back to the normal picker.
    assign w_locked  = (r_state == S_LOCK) && I_req[r_owner];
    assign w_cnt_inc = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + 1'b1;
    assign w_release = !I_lock[r_owner] || (32'(w_cnt_inc) >= 32'(P_lock_max));
    // With P_lock_max == 1 the entering grant already uses the whole budget.
    assign w_start_lock = !w_locked && w_pick_any && I_lock[w_pick_idx] && (P_lock_max > 1);

    always_comb begin
        w_gnt_idx = w_pick_idx;
        w_any     = w_pick_any;
        w_gnt_vec = w_pick_gnt;
        if (w_locked) begin
            w_gnt_idx = r_owner;
            w_any     = 1'b1;
            w_gnt_vec = {{(P_ports-1){1'b0}}, 1'b1} << r_owner;
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state    <= S_ARB;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            if (w_start_lock) begin
                r_state    <= S_LOCK;
                r_owner    <= w_pick_idx;
                r_lock_cnt <= LP_LOCK_CNT_BITS'(1);
            end else if (w_locked && !w_release) begin
                r_lock_cnt <= w_cnt_inc;
            end else begin
                r_state    <= S_ARB;
                r_lock_cnt <= '0;
            end
        end
    end
`else
    assign w_gnt_idx = w_pick_idx;
    assign w_any     = w_pick_any;
    assign w_gnt_vec = w_pick_gnt;
`endif

    // With no winner the RAM port shows the pointer port's address and data.
    assign w_sel = w_any ? w_gnt_idx : r_ptr;

    assign O_gnt      = I_reset ? '0 : w_gnt_vec;
    assign O_mem_wren = w_any && !I_reset && I_wren[w_gnt_idx];
    assign O_mem_addr = I_addr[w_sel*P_addr_bits +: P_addr_bits];
    assign O_mem_data = I_data[w_sel*P_data_bits +: P_data_bits];
    assign O_rdata    = I_mem_data;
    // Masking with I_reset drops a read whose data cycle coincides with reset.
    assign O_rvalid   = I_reset ? '0 : r_rvalid;

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_ptr    <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt_vec & ~I_wren;
            if (w_any) begin
                r_ptr <= LP_IDX_BITS'(fn_wrap_idx(int'(w_gnt_idx), 1, P_ports));
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Directed bench for memory_arbiter with three ports and a behavioural
// single-port RAM (write-through, 1-cycle registered read). The lock sequence
// is included when MEMORY_ARBITER_LOCK_EN is defined (P_lock_max = 4).
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int NP = 3;
    localparam int DB = 8;
    localparam int AB = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    req = '0;
    logic [NP-1:0]    wren = '0;
    logic [NP*AB-1:0] addr = '0;
    logic [NP*DB-1:0] data = '0;
`ifdef MEMORY_ARBITER_LOCK_EN
    logic [NP-1:0]    lock = '0;
`endif

    logic [NP-1:0]    gnt;
    logic [NP-1:0]    rvalid;
    logic [DB-1:0]    rdata;
    logic [AB-1:0]    mem_addr;
    logic             mem_wren;
    logic [DB-1:0]    mem_data;
    logic [DB-1:0]    mem_rdata;

    logic [DB-1:0]    mem [1024];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .P_ports     (NP),
        .P_data_bits (DB),
        .P_addr_bits (AB)
`ifdef MEMORY_ARBITER_LOCK_EN
        ,
        .P_lock_max  (4)
`endif
    ) u_dut (
        .I_clock    (clk),
        .I_reset    (rst),
        .I_req      (req),
        .I_wren     (wren),
        .I_addr     (addr),
        .I_data     (data),
`ifdef MEMORY_ARBITER_LOCK_EN
        .I_lock     (lock),
`endif
        .O_gnt      (gnt),
        .O_rvalid   (rvalid),
        .O_rdata    (rdata),
        .O_mem_addr (mem_addr),
        .O_mem_wren (mem_wren),
        .O_mem_data (mem_data),
        .I_mem_data (mem_rdata)
    );

    // Behavioural RAM: write-through, registered read.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_rdata <= mem_wren ? mem_data : mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [AB-1:0] a, input logic [DB-1:0] d);
        req[p]            = r;
        wren[p]           = w;
        addr[p*AB +: AB]  = a;
        data[p*DB +: DB]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name);
        $display("%0t %s req=%b wren=%b gnt=%b rvalid=%b maddr=%h mwren=%b mdata=%h rdata=%h",
                 $time, name, req, wren, gnt, rvalid, mem_addr, mem_wren, mem_data, rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [NP-1:0] rr_exp [6];
`ifdef MEMORY_ARBITER_LOCK_EN
    logic [NP-1:0] lk_exp [7];
`endif

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        mem[5] = 8'hA5;

        // Reset held with every port requesting.
        set_port(0, 1'b1, 1'b1, 10'h111, 8'h11);
        set_port(1, 1'b1, 1'b0, 10'h222, 8'h22);
        set_port(2, 1'b1, 1'b0, 10'h333, 8'h33);
        tick();
        show("reset");
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_wren", 32'(mem_wren), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        tick();

        // Idle for 5 cycles.
        rst = 1'b0;
        req = '0;
        wren = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            show("idle");
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_wren", 32'(mem_wren), 32'h0);
            chk("idle_rvalid", 32'(rvalid), 32'h0);
            tick();
        end
        chk("idle_ptr_addr", 32'(mem_addr), 32'h111);

        // Single read: port1 reads 0x005.
        set_port(1, 1'b1, 1'b0, 10'h005, 8'h00);
        #1;
        show("read_p1");
        chk("rd_gnt", 32'(gnt), 32'h2);
        chk("rd_maddr", 32'(mem_addr), 32'h005);
        chk("rd_mwren", 32'(mem_wren), 32'h0);
        tick();
        req = '0;
        #1;
        show("read_p1_data");
        chk("rd_rvalid", 32'(rvalid), 32'h2);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        chk("rd_ptr_addr", 32'(mem_addr), 32'h333);

        // Round robin from reset: all ports read continuously.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        wren = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            show("round_robin");
            chk("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
            if (k > 0) chk("rr_rvalid", 32'(rvalid), 32'(rr_exp[k-1]));
            tick();
        end

        // Write then read: port0 writes 0x3C to 0x010, port2 reads it back.
        req = '0;
        set_port(0, 1'b1, 1'b1, 10'h010, 8'h3C);
        #1;
        show("write_p0");
        chk("wr_prev_rvalid", 32'(rvalid), 32'h4);
        chk("wr_gnt", 32'(gnt), 32'h1);
        chk("wr_mwren", 32'(mem_wren), 32'h1);
        chk("wr_maddr", 32'(mem_addr), 32'h010);
        chk("wr_mdata", 32'(mem_data), 32'h3C);
        tick();
        set_port(0, 1'b0, 1'b0, 10'h010, 8'h3C);
        set_port(2, 1'b1, 1'b0, 10'h010, 8'h00);
        #1;
        show("read_p2");
        chk("wr_rd_gnt", 32'(gnt), 32'h4);
        chk("wr_rd_mwren", 32'(mem_wren), 32'h0);
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        tick();
        req = '0;
        #1;
        show("read_p2_data");
        chk("wr_rd_rvalid", 32'(rvalid), 32'h4);
        chk("wr_rd_rdata", 32'(rdata), 32'h3C);
        chk("wrap_ptr_addr", 32'(mem_addr), 32'h010);

        // Back-to-back reads from the same port.
        tick();
        set_port(2, 1'b1, 1'b0, 10'h005, 8'h00);
        #1;
        show("b2b_first");
        chk("b2b_gnt0", 32'(gnt), 32'h4);
        tick();
        #1;
        show("b2b_second");
        chk("b2b_gnt1", 32'(gnt), 32'h4);
        chk("b2b_rvalid0", 32'(rvalid), 32'h4);
        tick();
        req = '0;
        #1;
        show("b2b_data");
        chk("b2b_rvalid1", 32'(rvalid), 32'h4);
        chk("b2b_rdata", 32'(rdata), 32'hA5);

        // Reset in the cycle after a read grant drops the read.
        tick();
        set_port(1, 1'b1, 1'b0, 10'h005, 8'h00);
        #1;
        show("mid_read");
        chk("mid_gnt", 32'(gnt), 32'h2);
        tick();
        rst = 1'b1;
        req = '0;
        #1;
        show("mid_reset");
        chk("mid_rvalid", 32'(rvalid), 32'h0);
        chk("mid_gnt_rst", 32'(gnt), 32'h0);
        tick();
        rst = 1'b0;
        req = 3'b111;
        #1;
        show("after_reset");
        chk("mid_ptr_gnt", 32'(gnt), 32'h1);
        tick();
        req = '0;
        #1;
        chk("mid_after_rvalid", 32'(rvalid), 32'h1);

`ifdef MEMORY_ARBITER_LOCK_EN
        // Lock: port1 locks against ports 0 and 2 with P_lock_max = 4.
        lk_exp = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        lock = 3'b010;
        for (int k = 0; k < 7; k++) begin
            #1;
            show("lock");
            chk("lock_gnt", 32'(gnt), 32'(lk_exp[k]));
            tick();
        end
        req = '0;
        lock = '0;
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
